// File: rtl/mash_cic_decimator.sv
// Third-order CIC decimator that rebuilds PCM samples from the signed MASH bitstream.
// Optional CIC_DEC_ROUND_EN selects round-half-up with positive saturation instead of floor.
module mash_cic_decimator #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned R_LOG2 = 3,
    parameter int unsigned OUT_W  = 10
) (
    input  logic             clck,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  x,
    output logic             out_valid,
    output logic [OUT_W-1:0] y_out
);

    localparam int unsigned FULL_W = IN_W + 3 * R_LOG2;
    localparam int unsigned SHIFT  = FULL_W - OUT_W;
    localparam logic [R_LOG2-1:0] CNT_LAST = '1;

    logic [FULL_W-1:0] x_ext;
    logic [FULL_W-1:0] i1, i2, i3;
    logic [FULL_W-1:0] d1, d2, d3;
    logic [FULL_W-1:0] c1, c2, c3;
    logic [R_LOG2-1:0] cnt;
    logic              dec_stb;
    logic [OUT_W-1:0]  y_scaled_c;

    assign x_ext = FULL_W'($signed(x));

    // Comb differences are modular; wrap here cancels the integrator wrap.
    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    generate
        if (SHIFT == 0) begin : g_full
            assign y_scaled_c = c3;
        end else begin : g_scaled
`ifdef CIC_DEC_ROUND_EN
            localparam int unsigned SUM_W = FULL_W + 1;
            localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(1) <<< (SHIFT - 1);
            localparam logic signed [SUM_W-1:0] MAX_POS = SUM_W'((1 << (OUT_W - 1)) - 1);

            logic signed [SUM_W-1:0] sum_c;
            logic signed [SUM_W-1:0] rnd_c;

            // One extra bit keeps the rounding carry from wrapping into the sign.
            assign sum_c      = SUM_W'($signed(c3)) + HALF;
            assign rnd_c      = sum_c >>> SHIFT;
            assign y_scaled_c = (rnd_c > MAX_POS) ? OUT_W'(MAX_POS) : OUT_W'(rnd_c);
`else
            assign y_scaled_c = OUT_W'($signed(c3) >>> SHIFT);
`endif
        end
    endgenerate

    always_ff @(posedge clck) begin
        if (rst) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            cnt       <= '0;
            dec_stb   <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
        end else begin
            dec_stb   <= in_valid && (cnt == CNT_LAST);
            out_valid <= dec_stb;
            if (in_valid) begin
                i1  <= i1 + x_ext;
                i2  <= i2 + i1;
                i3  <= i3 + i2;
                cnt <= cnt + R_LOG2'(1);
            end
            if (dec_stb) begin
                d1    <= i3;
                d2    <= c1;
                d3    <= c2;
                y_out <= y_scaled_c;
            end
        end
    end

endmodule

// File: tb/tb_mash_cic_decimator.sv
// Directed bench for mash_cic_decimator (R=8, OUT_W=10) with an impulse-response reference.
module tb_mash_cic_decimator;

    localparam int unsigned IN_W   = 4;
    localparam int unsigned R_LOG2 = 3;
    localparam int unsigned OUT_W  = 10;

    logic             clck = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IN_W-1:0]  x;
    logic             out_valid;
    logic [OUT_W-1:0] y_out;
    logic signed [OUT_W-1:0] ys;

    int n_checks = 0;
    int n_pass   = 0;
    int hist[$];
    int pulse_q[$];
    int acc;
    bit pend;
    bit model_on;
    int cyc = 0;
    int last_pulse;
    int last_gap;
    int last_y;
    int mark;

    assign ys = y_out;

    mash_cic_decimator #(.IN_W(IN_W), .R_LOG2(R_LOG2), .OUT_W(OUT_W)) dut (
        .clck     (clck),
        .rst      (rst),
        .in_valid (in_valid),
        .x        (x),
        .out_valid(out_valid),
        .y_out    (y_out)
    );

    always #5 clck = ~clck;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Third integrator after n samples: sum of x[k] * C(n-1-k, 2).
    function automatic longint i3_of(input int n);
        longint s = 0;
        longint m;
        if (n <= 0) return 0;
        for (int k = 0; k < n; k++) begin
            m = longint'(n - 1 - k);
            s += longint'(hist[k]) * (m * (m - 1) / 2);
        end
        return s;
    endfunction

    function automatic longint model_y(input int n);
        longint c3;
        longint r;
        c3 = i3_of(n) - 3 * i3_of(n - 8) + 3 * i3_of(n - 16) - i3_of(n - 24);
`ifdef CIC_DEC_ROUND_EN
        r = (c3 + 4) >>> 3;
        if (r > 511) r = 511;
`else
        r = c3 >>> 3;
`endif
        return r;
    endfunction

    task automatic step(input bit v, input int xv);
        in_valid = v;
        x        = IN_W'(xv);
        @(posedge clck);
        #1;
        cyc++;
        if (model_on) begin
            check("out_valid", longint'(out_valid), longint'(pend));
            if (pend) check("y_out", longint'(ys), model_y(acc));
        end
        if (out_valid) begin
            last_gap   = cyc - last_pulse;
            last_pulse = cyc;
            last_y     = int'(ys);
            pulse_q.push_back(int'(ys));
        end
        pend = 1'b0;
        if (v) begin
            if (model_on) hist.push_back(xv);
            acc++;
            if (acc % 8 == 0) pend = 1'b1;
        end
    endtask

    task automatic do_reset(input bit v);
        rst      = 1'b1;
        in_valid = v;
        x        = IN_W'(7);
        @(posedge clck);
        #1;
        cyc++;
        rst = 1'b0;
        hist.delete();
        pulse_q.delete();
        acc        = 0;
        pend       = 1'b0;
        last_pulse = cyc;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y_out", longint'(ys), 0);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        model_on = 1'b1;

        // DC x=1: 56>>3, 392>>3, then 512>>3
        do_reset(1'b0);
        for (int i = 0; i < 48; i++) step(1'b1, 1);
        step(1'b0, 0);
        check("dc1_pulses", longint'(pulse_q.size()), 6);
        check("dc1_p0", longint'(pulse_q[0]), 7);
        check("dc1_p1", longint'(pulse_q[1]), 49);
        check("dc1_p4", longint'(pulse_q[4]), 64);
        check("dc1_gap", longint'(last_gap), 8);

        do_reset(1'b0);
        for (int i = 0; i < 48; i++) step(1'b1, -8);
        step(1'b0, 0);
        check("dcm8_settled", longint'(last_y), -512);
        check("dcm8_p0", longint'(pulse_q[0]), -56);

        // Long run: integrators wrap many times
        model_on = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 20000; i++) step(1'b1, 7);
        step(1'b0, 0);
        check("dc7_long", longint'(last_y), 448);
        check("dc7_gap", longint'(last_gap), 8);
        model_on = 1'b1;

        do_reset(1'b0);
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1);
            step(1'b0, 0);
        end
        check("gap_period", longint'(last_gap), 16);
        check("gap_p0", longint'(pulse_q[0]), 7);
        check("gap_p1", longint'(pulse_q[1]), 49);
        check("gap_p5", longint'(pulse_q[5]), 64);

        // Mid-frame reset, with in_valid high during reset
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1);
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 3);
        step(1'b1, 3);
        mark = cyc;
        check("mid_no_early", longint'(out_valid), 0);
        step(1'b0, 0);
        check("mid_latency", longint'(last_pulse - mark), 1);
        check("mid_value", longint'(last_y), 21);
        step(1'b0, 0);
        check("mid_pulse_width", longint'(out_valid), 0);
        check("mid_hold", longint'(ys), 21);

        do_reset(1'b0);
        for (int i = 0; i < 400; i++)
            step(($urandom_range(3) != 0), int'($urandom_range(15)) - 8);
        for (int i = 0; i < 3; i++) step(1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
